multicycle_addsub: RTL and testbench



---
 rtl/multicycle_addsub_pkg.sv | 21 ++
 rtl/multicycle_addsub_chunk_adder.sv | 40 ++++
 rtl/multicycle_addsub.sv | 130 +++++++++++++
 tb/tb_multicycle_addsub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor.
//   state_e : controller state encoding (IDLE / RUN / DONE)
//   clog2   : ceiling log2, used to size the chunk step counter
package multicycle_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/multicycle_addsub_chunk_adder.sv
// Combinational CHUNK-bit carry-lookahead adder.
//   a, b   : chunk operands
//   ci     : carry into bit 0
//   s      : chunk sum
//   co     : carry out of the chunk MSB
//   c_msb  : carry into the chunk MSB (XOR with co gives signed overflow)
module chunk_adder
    import multicycle_addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Generate/propagate recurrence; synthesis flattens it into lookahead terms.
    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s     = p ^ c[CHUNK-1:0];
    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_addsub.sv
// WIDTH-bit add/subtract computed CHUNK bits per clock with a registered carry.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request, honoured in IDLE or DONE only
//   sub               : 0 = A + B + cin, 1 = A + ~B + ~cin (borrow-in on cin)
//   A, B, cin         : operands, captured on the accepting edge
//   busy              : high while chunks are being processed
//   done              : one-cycle pulse when S/cout/ovf are final
//   S, cout, ovf      : result, carry/no-borrow out, signed overflow
module multicycle_addsub
    import multicycle_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int SW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("multicycle_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e           state_q;
    logic [SW-1:0]    step_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             carry_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             co_chunk;
    logic             cmsb_chunk;
    logic             accept_d;

    // One adder shared across all steps; the step counter selects the slice.
    assign a_chunk  = opa_q[step_q*CHUNK +: CHUNK];
    assign b_chunk  = opb_q[step_q*CHUNK +: CHUNK];
    assign accept_d = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (carry_q),
        .s     (sum_chunk),
        .co    (co_chunk),
        .c_msb (cmsb_chunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (accept_d) begin
                        // Subtract folds into an add: invert B, borrow-in becomes ~cin.
                        opa_q   <= A;
                        opb_q   <= sub ? ~B : B;
                        carry_q <= cin ^ sub;
                        s_q     <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    s_q[step_q*CHUNK +: CHUNK] <= sum_chunk;
                    carry_q <= co_chunk;
                    if (step_q == LAST_STEP) begin
                        step_q  <= '0;
                        cout_q  <= co_chunk;
                        ovf_q   <= cmsb_chunk ^ co_chunk;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        step_q <= step_q + SW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
module tb_multicycle_addsub;

    logic clk;
    logic rst_n;

    logic        start16, sub16, cin16;
    logic [15:0] A16, B16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] S16;

    logic        swstart, swsub, swcin;
    logic [31:0] swA, swB;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] S32;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  S8;

    int total = 0;
    int bad   = 0;
    int ndone = 0;

    multicycle_addsub #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .A(A16), .B(B16),
        .cin(cin16), .busy(busy16), .done(done16), .S(S16), .cout(cout16), .ovf(ovf16));

    multicycle_addsub #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .start(swstart), .sub(swsub), .A(swA), .B(swB),
        .cin(swcin), .busy(busy32), .done(done32), .S(S32), .cout(cout32), .ovf(ovf32));

    multicycle_addsub #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(swstart), .sub(swsub), .A(swA[7:0]), .B(swB[7:0]),
        .cin(swcin), .busy(busy8), .done(done8), .S(S8), .cout(cout8), .ovf(ovf8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic. Returns {ovf, cout, S}.
    function automatic logic [65:0] ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic ci, input logic sb);
        logic [63:0] mask, ma, mb, r, s;
        logic co, ov;
        mask = (64'd1 << w) - 64'd1;
        ma = a & mask;
        mb = b & mask;
        r  = sb ? (ma - mb - 64'(ci)) : (ma + mb + 64'(ci));
        s  = r & mask;
        co = sb ? ~r[w] : r[w];
        if (sb) ov = (ma[w-1] != mb[w-1]) && (s[w-1] != ma[w-1]);
        else    ov = (ma[w-1] == mb[w-1]) && (s[w-1] != ma[w-1]);
        return {ov, co, s};
    endfunction

    // Cycle-level model of the 16-bit unit: cycles left in flight plus visible result.
    int          m_cnt;
    logic        m_done;
    logic [15:0] m_S;
    logic        m_cout, m_ovf;
    logic [65:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_S    <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_pend <= '0;
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) begin
                m_S    <= m_pend[15:0];
                m_cout <= m_pend[64];
                m_ovf  <= m_pend[65];
            end
        end else begin
            m_done <= 1'b0;
            if (start16) begin
                m_pend <= ref_op(16, 64'(A16), 64'(B16), cin16, sub16);
                m_cnt  <= 4;
                m_S    <= '0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy16", 66'(busy16), 66'(m_cnt != 0));
        chk("done16", 66'(done16), 66'(m_done));
        if (m_cnt == 0) begin
            chk("S16", 66'(S16), 66'(m_S));
            chk("cout16", 66'(cout16), 66'(m_cout));
            chk("ovf16", 66'(ovf16), 66'(m_ovf));
        end
        if (done16) ndone++;
    end

    task automatic op16(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb,
                        input logic [15:0] eS, input logic ec, input logic eo);
        int k;
        @(negedge clk);
        A16 = a; B16 = b; cin16 = ci; sub16 = sb; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        A16 = 16'($urandom); B16 = 16'($urandom); cin16 = 1'($urandom);
        k = 0;
        while (!done16 && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_lat"}, 66'(k), 66'd4);
        chk({nm, "_S"}, 66'(S16), 66'(eS));
        chk({nm, "_cout"}, 66'(cout16), 66'(ec));
        chk({nm, "_ovf"}, 66'(ovf16), 66'(eo));
    endtask

    task automatic sweep(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
        logic [65:0] r32, r8, g32, g8;
        int k, lat32, lat8;
        r32 = ref_op(32, 64'(a), 64'(b), ci, sb);
        r8  = ref_op(8, 64'(a), 64'(b), ci, sb);
        g32 = '0; g8 = '0;
        lat32 = -1; lat8 = -1;
        @(negedge clk);
        swA = a; swB = b; swcin = ci; swsub = sb; swstart = 1'b1;
        @(negedge clk);
        swstart = 1'b0;
        chk("sw_busy32", 66'(busy32), 66'd1);
        chk("sw_busy8", 66'(busy8), 66'd1);
        k = 0;
        while ((lat32 < 0 || lat8 < 0) && k < 12) begin
            @(negedge clk);
            k++;
            if (done32 && lat32 < 0) begin lat32 = k; g32 = {ovf32, cout32, 32'd0, S32}; end
            if (done8 && lat8 < 0) begin lat8 = k; g8 = {ovf8, cout8, 56'd0, S8}; end
        end
        chk("sw_lat32", 66'(lat32), 66'd4);
        chk("sw_lat8", 66'(lat8), 66'd1);
        chk("sw_res32", g32, r32);
        chk("sw_res8", g8, r8);
    endtask

    initial begin
        int k, d0;
        rst_n = 1'b0;
        start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; A16 = '0; B16 = '0;
        swstart = 1'b0; swsub = 1'b0; swcin = 1'b0; swA = '0; swB = '0;
        repeat (2) @(negedge clk);
        chk("rst_out16", {busy16, done16, cout16, ovf16, S16}, 66'd0);
        chk("rst_out32", {busy32, done32, cout32, ovf32, S32}, 66'd0);
        rst_n = 1'b1;

        chk("model_add", ref_op(16, 64'd65000, 64'd65340, 1'b0, 1'b0), {2'b01, 64'd64804});
        chk("model_sub", ref_op(16, 64'd1005, 64'd69, 1'b0, 1'b1), {2'b01, 64'd936});
        chk("model_subneg", ref_op(16, 64'd69, 64'd1005, 1'b0, 1'b1), {2'b00, 64'd64600});
        chk("model_ovf", ref_op(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0), {2'b10, 64'h8000});

        op16("t1_add", 16'd65000, 16'd65340, 1'b0, 1'b0, 16'd64804, 1'b1, 1'b0);
        op16("t2_sub", 16'd1005, 16'd69, 1'b0, 1'b1, 16'd936, 1'b1, 1'b0);
        op16("t2_subneg", 16'd69, 16'd1005, 1'b0, 1'b1, 16'd64600, 1'b0, 1'b0);
        op16("t3_ovfadd", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16("t3_ovfsub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Start held through RUN with changing operands, then back-to-back in DONE.
        repeat (2) @(negedge clk);
        #1 d0 = ndone;
        @(negedge clk);
        A16 = 16'd15124; B16 = 16'd5383; cin16 = 1'b1; sub16 = 1'b0; start16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A16 = 16'($urandom); B16 = 16'($urandom);
        end
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        chk("t4_done", 66'(done16), 66'd1);
        chk("t4_S", 66'(S16), 66'd20508);
        A16 = 16'd50; B16 = 16'd10024; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        k = 1;
        while (!done16 && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk("t4_b2b_gap", 66'(k), 66'd5);
        chk("t4_b2b_S", 66'(S16), 66'd10074);
        repeat (4) @(negedge clk);
        #1 chk("t4_pulses", 66'(ndone - d0), 66'd2);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        A16 = 16'd1234; B16 = 16'd4321; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t5_rst_out", {busy16, done16, cout16, ovf16, S16}, 66'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = ndone;
        repeat (8) @(negedge clk);
        #1 chk("t5_no_done", 66'(ndone), 66'(d0));
        op16("t5_after", 16'd1005, 16'd69, 1'b1, 1'b0, 16'd1075, 1'b0, 1'b0);

        // Wide and single-chunk configurations.
        sweep(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        sweep(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sweep($urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
